// File: rtl/deadlock_idx0_monitor.sv
// Deadlock monitor: flags a stall once every channel is settled and a block source persists.
// Optional build macro DEADLOCK_MONITOR_STICKY_EN latches block until reset.
module deadlock_idx0_monitor #(
    parameter int AXIS_NUM = 5,
    parameter int INST_NUM = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AXIS_NUM-1:0] axis_block_sigs,
    input  logic [AXIS_NUM-1:0] inst_idle_sigs,
    input  logic [INST_NUM-1:0] inst_block_sigs,
    output logic                block
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic          cand_d;
    logic          cand_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          at_max;

    // All-idle with nothing blocking is quiescence, not deadlock.
    always_comb begin
        cand_d = (&(axis_block_sigs | inst_idle_sigs)) &
                 ((|axis_block_sigs) | (|inst_block_sigs));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!cand_q) begin
            cnt_d = '0;
        end else if (cnt_q < TMAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign at_max = (cnt_q == TMAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef DEADLOCK_MONITOR_STICKY_EN
    logic sticky_d;
    logic sticky_q;

    always_comb begin
        sticky_d = sticky_q | at_max;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign block = sticky_q | at_max;
`else
    assign block = at_max;
`endif

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed self-checking bench for deadlock_idx0_monitor (TIMEOUT=4).
// Expected values are hand-derived edge by edge from the stall/timeout rules.
module tb_deadlock_idx0_monitor;

    logic       clock;
    logic       reset;
    logic [4:0] axis_block_sigs;
    logic [4:0] inst_idle_sigs;
    logic [0:0] inst_block_sigs;
    logic       block;

    int errors;
    int checks;

    deadlock_idx0_monitor #(
        .AXIS_NUM(5),
        .INST_NUM(1),
        .TIMEOUT (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .block          (block)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [4:0] ab, input logic [4:0] id,
                          input logic ib);
        axis_block_sigs = ab;
        inst_idle_sigs  = id;
        inst_block_sigs = ib;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(5'b00001, 5'b11110, 1'b0);
        #2;
        checks++;
        if (block !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=0", block);
        end
        for (int e = 1; e <= 6; e++) begin
            step();
            checks++;
            if (block !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge=%0d got=%b exp=0", e, block);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_stall();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        set_in(5'b00001, 5'b11110, 1'b0);
        for (int e = 1; e <= 14; e++) begin
            logic exp;
            step();
            exp = (e >= 5);
            checks++;
            if (block !== exp) begin
                errors++;
                $display("FAIL stall edge=%0d got=%b exp=%b", e, block, exp);
            end
        end
    endtask

    task automatic test_inst_block();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        set_in(5'b00000, 5'b11111, 1'b1);
        for (int e = 1; e <= 7; e++) begin
            logic exp;
            step();
            exp = (e >= 5);
            checks++;
            if (block !== exp) begin
                errors++;
                $display("FAIL inst_block edge=%0d got=%b exp=%b", e, block, exp);
            end
        end
    endtask

    task automatic test_all_idle();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        set_in(5'b00000, 5'b11111, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (block !== 1'b0) begin
                errors++;
                $display("FAIL all_idle edge=%0d got=%b exp=0", e, block);
            end
        end
    endtask

    task automatic test_unsettled();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        set_in(5'b00001, 5'b11100, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            step();
            checks++;
            if (block !== 1'b0) begin
                errors++;
                $display("FAIL unsettled edge=%0d got=%b exp=0", e, block);
            end
        end
    endtask

    task automatic test_glitch();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        for (int e = 1; e <= 11; e++) begin
            logic exp;
            if (e == 3) set_in(5'b00000, 5'b11110, 1'b0);
            else        set_in(5'b00001, 5'b11110, 1'b0);
            step();
            exp = (e >= 8);
            checks++;
            if (block !== exp) begin
                errors++;
                $display("FAIL glitch edge=%0d got=%b exp=%b", e, block, exp);
            end
        end
    endtask

    task automatic test_release();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        set_in(5'b00001, 5'b11110, 1'b0);
        for (int e = 1; e <= 6; e++) step();
        checks++;
        if (block !== 1'b1) begin
            errors++;
            $display("FAIL release_pre got=%b exp=1", block);
        end
        set_in(5'b00000, 5'b00000, 1'b0);
        for (int e = 7; e <= 11; e++) begin
            logic exp;
            step();
`ifdef DEADLOCK_MONITOR_STICKY_EN
            exp = 1'b1;
`else
            exp = (e == 7);
`endif
            checks++;
            if (block !== exp) begin
                errors++;
                $display("FAIL release edge=%0d got=%b exp=%b", e, block, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(5'b00000, 5'b00000, 1'b0);
        pulse_reset();
        set_in(5'b00001, 5'b11110, 1'b0);
        for (int e = 1; e <= 6; e++) step();
        checks++;
        if (block !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got=%b exp=1", block);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (block !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async got=%b exp=0", block);
        end
        #2;
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            logic exp;
            step();
            exp = (e >= 5);
            checks++;
            if (block !== exp) begin
                errors++;
                $display("FAIL reset_mid_restall edge=%0d got=%b exp=%b",
                         e, block, exp);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set_in(5'b00000, 5'b00000, 1'b0);
        test_reset();
        test_stall();
        test_inst_block();
        test_all_idle();
        test_unsettled();
        test_glitch();
        test_release();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deadlock_idx0_monitor.md
DEADLOCK_IDX0_MONITOR -- requirements
Module: deadlock_idx0_monitor

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter AXIS_NUM, default 5: number of AXI-Stream block/idle channel pairs.
REQ-003 Parameter INST_NUM, default 1: number of sub-instance block inputs.
REQ-004 Parameter TIMEOUT, default 16, minimum 1: number of consecutive stalled cycles required before block is flagged.
REQ-005 clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 axis_block_sigs  input  AXIS_NUM  bit i=1: channel i is stalled on its AXI-Stream port (full or empty).
REQ-008 inst_idle_sigs  input  AXIS_NUM  bit i=1: the sub-instance owning channel i is idle.
REQ-009 inst_block_sigs  input  INST_NUM  bit j=1: sub-instance j reports an internal block.
REQ-010 block  output  1  1 = deadlock detected.

Function
REQ-011 Channel i SHALL be "settled" when axis_block_sigs[i] | inst_idle_sigs[i] = 1.
REQ-012 The stall candidate SHALL be (AND of all settled bits) AND (OR of all axis_block_sigs bits OR OR of all inst_block_sigs bits).
- All-idle with no block source is not a deadlock.
REQ-013 The candidate SHALL be registered every cycle into cand_q, giving 1 cycle of input latency.
REQ-014 Counter cnt SHALL be cleared to 0 on any edge where cand_q = 0.
REQ-015 On edges where cand_q = 1 and cnt < TIMEOUT, cnt SHALL increment by 1.
REQ-016 cnt SHALL saturate at TIMEOUT and never wrap.
REQ-017 cnt width SHALL be the smallest width able to hold TIMEOUT.
REQ-018 block SHALL equal (cnt == TIMEOUT), driven directly from registers with no combinational path from the inputs.
REQ-019 With the candidate held true from before edge 1, block SHALL rise after edge TIMEOUT+1.
REQ-020 A single non-candidate cycle SHALL clear cnt and restart the full TIMEOUT count.
REQ-021 When the sticky option (REQ-026) is absent, block SHALL fall 1 edge after cand_q falls, i.e. 2 edges after the candidate input falls.
REQ-022 Input bits that change simultaneously SHALL be evaluated as one combined candidate per cycle, with no per-bit ordering.

Reset
REQ-023 While reset = 1, cand_q, cnt and block SHALL be 0 regardless of the clock.
REQ-024 Reset asserted mid-count or while block = 1 SHALL clear all state immediately and asynchronously.
REQ-025 After reset deasserts, counting SHALL restart from 0 at the first rising edge.

Configuration
REQ-026 When macro DEADLOCK_MONITOR_STICKY_EN is defined, block SHALL latch to 1 once reached and stay 1 until reset, regardless of later candidate values.
REQ-027 When DEADLOCK_MONITOR_STICKY_EN is undefined, block SHALL follow REQ-018 and REQ-021 (non-sticky).

Verification (TIMEOUT=4, AXIS_NUM=5, INST_NUM=1)
REQ-028 Idle=5'b11110, axis_block=5'b00001, inst_block=0, held -> block=0 through edge 4; block=1 from edge 5 onward.
REQ-029 Idle=5'b11111, axis_block=0, inst_block=0 held 20 cycles -> block stays 0.
REQ-030 Idle=5'b11100, axis_block=5'b00001 (channel 1 neither settled nor blocked) -> block stays 0 indefinitely.
REQ-031 Stalled pattern of REQ-028 with axis_block[0] dropped for 1 cycle at edge 3 -> block=0 until 5 edges after the candidate returns.
REQ-032 block=1, then all inputs cleared -> block=0 two edges later (non-sticky build); block stays 1 with DEADLOCK_MONITOR_STICKY_EN defined.
REQ-033 block=1, then reset pulsed mid-cycle -> block=0 immediately; re-stalling -> block=1 after 5 edges.
